// File: rtl/jtag_scan_pkg.sv
// Shared types and TMS sequences for the JTAG scan master.
// Each TMS constant has bit i = tms on pulse i of that phase.
package jtag_scan_pkg;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'd0,
    OP_IR_SCAN   = 2'd1,
    OP_DR_SCAN   = 2'd2,
    OP_RSVD      = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_TRL,
    ST_RESP
  } state_e;

  // Test-Logic-Reset (5x tms=1), then Run-Test/Idle
  localparam logic [7:0] INIT_TMS      = 8'b0001_1111;
  localparam int         INIT_PULSES   = 6;
  // Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [7:0] IR_HDR_TMS    = 8'b0000_0011;
  localparam int         IR_HDR_PULSES = 4;
  // Idle -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [7:0] DR_HDR_TMS    = 8'b0000_0001;
  localparam int         DR_HDR_PULSES = 3;
  // Exit1 -> Update -> Run-Test/Idle
  localparam logic [7:0] TRL_TMS       = 8'b0000_0001;
  localparam int         TRL_PULSES    = 2;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: while enabled, each bit-period is DIV clk cycles low then
// DIV cycles high. Strobes flag the clk edge on which tck will rise/fall.
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] ph;
  logic          ph_end;

  assign ph_end   = (ph == PW'(DIV - 1));
  assign fall_stb = en && tck && ph_end;
  assign rise_stb = en && !tck && ph_end;

  // Disabled holds tck low with the phase counter parked, so every
  // enable starts cleanly at the beginning of a low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph  <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      ph  <= '0;
      tck <= 1'b0;
    end else if (ph_end) begin
      ph  <= '0;
      tck <= ~tck;
    end else begin
      ph  <= ph + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// Command-driven JTAG master: TAP reset, IR and DR scans from Run-Test/Idle,
// one response per accepted command with the captured TDO bits.
module jtag_scan_master
  import jtag_scan_pkg::*;
#(
  parameter int  DIV     = 2,
  parameter int  MAX_LEN = 64,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int IW = $clog2(MAX_LEN);

  state_e             state, nxt;
  cmd_op_e            op_q;
  logic [LW-1:0]      cnt, len_q, len_c, last_cnt;
  logic [2:0]         nidx;
  logic [MAX_LEN-1:0] dat, cap;
  logic               rst_cmd, accept, last, tck_en, fall_stb, rise_stb;

  jtag_tck_gen #(.DIV(DIV)) u_tck (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tck_en),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  assign len_c  = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign accept = cmd_valid && cmd_ready;
  assign nidx   = cnt[2:0] + 3'd1;
  assign last   = (cnt == last_cnt);

  always_comb begin
    last_cnt = '0;
    unique case (state)
      ST_INIT:  last_cnt = LW'(INIT_PULSES - 1);
      ST_HDR:   last_cnt = (op_q == OP_IR_SCAN) ? LW'(IR_HDR_PULSES - 1)
                                                : LW'(DR_HDR_PULSES - 1);
      ST_SHIFT: last_cnt = len_q - LW'(1);
      ST_TRL:   last_cnt = LW'(TRL_PULSES - 1);
      default:  last_cnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_INIT:  if (fall_stb && last) nxt = rst_cmd ? ST_RESP : ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd_op_e'(cmd_op))
            OP_TAP_RESET:           nxt = ST_INIT;
            OP_IR_SCAN, OP_DR_SCAN: nxt = (len_c != '0) ? ST_HDR : ST_RESP;
            default:                nxt = ST_RESP;
          endcase
        end
      end
      ST_HDR:   if (fall_stb && last) nxt = ST_SHIFT;
      ST_SHIFT: if (fall_stb && last) nxt = ST_TRL;
      ST_TRL:   if (fall_stb && last) nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) nxt = ST_IDLE;
      default:  nxt = ST_INIT;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    tck_en    = 1'b0;
    unique case (state)
      ST_IDLE:                       cmd_ready = 1'b1;
      ST_RESP:                       rsp_valid = 1'b1;
      ST_INIT, ST_HDR, ST_SHIFT, ST_TRL: tck_en = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data = cap;

  // tms/tdi for pulse n+1 are loaded on the edge where pulse n's tck falls;
  // pulse 0 values are loaded at acceptance (or by reset for INIT).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_TAP_RESET;
      len_q   <= '0;
      cnt     <= '0;
      rst_cmd <= 1'b0;
      dat     <= '0;
      cap     <= '0;
      tms     <= 1'b1;
      tdi     <= 1'b0;
    end else if (accept) begin
      op_q    <= cmd_op_e'(cmd_op);
      len_q   <= len_c;
      cnt     <= '0;
      rst_cmd <= (cmd_op_e'(cmd_op) == OP_TAP_RESET);
      dat     <= cmd_data;
      cap     <= '0;
      tms     <= (nxt == ST_INIT) || (nxt == ST_HDR);
    end else begin
      if (rise_stb && state == ST_SHIFT) cap[cnt[IW-1:0]] <= tdo;
      if (fall_stb) begin
        cnt <= last ? '0 : cnt + 1'b1;
        unique case (state)
          ST_INIT: tms <= last ? 1'b0 : INIT_TMS[nidx];
          ST_HDR: begin
            if (last) begin
              tms <= (len_q == LW'(1));
              tdi <= dat[0];
              dat <= dat >> 1;
            end else begin
              tms <= (op_q == OP_IR_SCAN) ? IR_HDR_TMS[nidx] : DR_HDR_TMS[nidx];
            end
          end
          ST_SHIFT: begin
            if (last) begin
              tms <= TRL_TMS[0];
              tdi <= 1'b0;
            end else begin
              tms <= (cnt + 1'b1 == last_cnt);
              tdi <= dat[0];
              dat <= dat >> 1;
            end
          end
          ST_TRL:  tms <= last ? 1'b0 : TRL_TMS[nidx];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 Parameter DIV, 2, TCK half-period in clk cycles (>=1).
REQ-002 Parameter MAX_LEN, 64, maximum scan length in bits.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  in  2  command: 0 TAP_RESET, 1 IR_SCAN, 2 DR_SCAN, 3 reserved.
REQ-008 cmd_len  in  clog2(MAX_LEN+1)  scan length in bits.
REQ-009 cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-012 rsp_data  out  MAX_LEN  captured TDO bits, LSB first.
REQ-013 tck  out  1  JTAG test clock.
REQ-014 tms  out  1  JTAG mode select.
REQ-015 tdi  out  1  JTAG data to target.
REQ-016 tdo  in  1  JTAG data from target.

Function
REQ-017 Each TCK bit-period SHALL be 2*DIV clk cycles: tck low for the first DIV cycles, then high for DIV cycles.
REQ-018 tms and tdi SHALL change only on the clk edge where tck goes low; tdo SHALL be registered on the clk edge where tck goes high.
REQ-019 The FSM SHALL have states INIT, IDLE, HDR, SHIFT, TRL, RESP; all scans start and end in TAP Run-Test/Idle.
REQ-020 INIT: 6 TCK pulses with tms 1,1,1,1,1,0, then IDLE. INIT runs automatically after reset release and for TAP_RESET.
REQ-021 IR_SCAN header: tms 1,1,0,0. DR_SCAN header: tms 1,0,0.
REQ-022 SHIFT: len pulses; tdi = cmd_data[i] on pulse i; tms=0 except on the last pulse (tms=1).
REQ-023 TRL: 2 pulses, tms 1 then 0.
REQ-024 rsp_data[i] SHALL hold tdo sampled on shift pulse i; bits >= len SHALL be 0.
REQ-025 cmd_ready SHALL be 1 only in IDLE with no pending response.
REQ-026 Every accepted command SHALL produce exactly one response: rsp_valid rises the cycle after the final TCK high phase ends. For TAP_RESET, rsp_data SHALL be 0.
REQ-027 rsp_valid and rsp_data SHALL hold until rsp_ready; the FSM returns to IDLE on the handshake cycle.
REQ-028 cmd_len=0 on a scan SHALL produce no TCK activity, and rsp_data=0 with rsp_valid on the next cycle. cmd_len>MAX_LEN SHALL clamp to MAX_LEN. cmd_op=3 SHALL behave as len=0.
REQ-029 cmd_data, cmd_op and cmd_len SHALL be latched at acceptance; input changes mid-scan SHALL have no effect.
REQ-030 tck SHALL idle low outside INIT, HDR, SHIFT and TRL. tms SHALL idle 0 after INIT.

Reset
REQ-031 While rst_n=0, outputs SHALL be tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, and the FSM SHALL be in INIT with counters cleared.
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no response produced. On release, the full INIT sequence SHALL run before cmd_ready rises.

Structure
REQ-033 Package jtag_scan_pkg SHALL hold the cmd_op enum, the FSM state enum, and the header/trailer TMS constants.
REQ-034 The divider/phase generator SHALL be sub-module jtag_tck_gen (outputs: tck, fall_stb, rise_stb). The FSM and shift registers SHALL live in jtag_scan_master.

Verification
REQ-035 Reset release with DIV=2 -> 6 tck pulses with tms 1,1,1,1,1,0, and cmd_ready=1 at clk 24 after release.
REQ-036 IR_SCAN len=4, data=0x5, tdo tied 0 -> 10 pulses; tms 1,1,0,0,0,0,0,1,1,0; tdi on shift pulses 1,0,1,0; rsp_data=0.
REQ-037 DR_SCAN len=32, tdo tied 1 -> 37 pulses; rsp_data=0xFFFFFFFF with upper bits 0.
REQ-038 DR_SCAN len=8 with tdo = tdi delayed one TCK (1-bit target model), data 0xA5 -> rsp_data=0x4A.
REQ-039 rsp_ready held 0 for 20 cycles after rsp_valid -> rsp_valid and rsp_data stable, cmd_ready=0, tck low throughout.
REQ-040 rst_n pulsed low at shift pulse 10 of a len=32 DR_SCAN -> outputs at reset values immediately, no rsp_valid, and the INIT sequence repeats on release.
